dmem_master: RTL and testbench

Initiator side of the data memory port. Accepts load, store and block-copy requests from the CPU core over a valid/ready handshake. Drives the memory's address, offset, write-enable and write-data lines, and captures the memory's combinational read data. Returns one response pulse per request. Sits between the core datapath and the 256-deep data memory.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_master.sv | 192 +++++++++++++++++++
 tb/tb_dmem_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory initiator.
package dmem_pkg;

    localparam int unsigned DMEM_W = 8;
    localparam int unsigned DMEM_A = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        COPY_RD = 2'b10,
        COPY_WR = 2'b11
    } state_t;

    // Only a store writes during ACCESS; the reserved opcode behaves as a load.
    function automatic logic op_is_store(input op_t op);
        return (op == OP_STORE);
    endfunction

endpackage

// File: rtl/dmem_master.sv
// Initiator for the data memory port: load, store and ascending block copy
// driven through a two-process FSM, one response pulse per accepted request.
module dmem_master
    import dmem_pkg::*;
#(
    parameter int unsigned W = DMEM_W,
    parameter int unsigned A = DMEM_A
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic [1:0]   ReqOp,
    input  logic [A-1:0] ReqAddr,
    input  logic [A-1:0] ReqOffset,
    input  logic [A-1:0] ReqDst,
    input  logic [A-1:0] ReqLen,
    input  logic [W-1:0] ReqData,
    output logic         RspValid,
    output logic [W-1:0] RspData,
    output logic         Busy,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddress,
    output logic [A-1:0] MemOffset,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut
);

    state_t       r_state;
    state_t       w_next_state;
    op_t          r_op;
    op_t          w_req_op;
    logic [A-1:0] r_addr;
    logic [A-1:0] r_offset;
    logic [A-1:0] r_dst;
    logic [A-1:0] r_len;
    logic [A-1:0] r_idx;
    logic [A-1:0] w_idx_next;
    logic         w_last;
    logic [W-1:0] r_data;
    logic [W-1:0] r_buf;
    logic         r_rsp_valid;
    logic [W-1:0] r_rsp_data;
    logic         w_accept;
    logic         w_ready;

    // Ready is held low while Reset is asserted so nothing is taken during reset.
    assign w_ready    = (r_state == IDLE) && !Reset;
    assign w_accept   = ReqValid && w_ready;
    assign w_req_op   = op_t'(ReqOp);
    assign w_idx_next = r_idx + {{(A-1){1'b0}}, 1'b1};
    assign w_last     = (w_idx_next == r_len);

    assign ReqReady = w_ready;
    assign Busy     = (r_state != IDLE);
    assign RspValid = r_rsp_valid;
    assign RspData  = r_rsp_data;

    // State register; async reset aborts any operation in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a zero-length copy completes without leaving IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (w_req_op)
                        OP_LOAD:  w_next_state = ACCESS;
                        OP_STORE: w_next_state = ACCESS;
                        OP_RSVD:  w_next_state = ACCESS;
                        OP_COPY: begin
                            if (ReqLen != {A{1'b0}}) begin
                                w_next_state = COPY_RD;
                            end else begin
                                w_next_state = IDLE;
                            end
                        end
                        default:  w_next_state = IDLE;
                    endcase
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS:  w_next_state = IDLE;
            COPY_RD: w_next_state = COPY_WR;
            COPY_WR: begin
                if (w_last) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = COPY_RD;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Memory port drive, decoded from state so write-enable falls with reset.
    always_comb begin
        MemWriteEn = 1'b0;
        MemAddress = {A{1'b0}};
        MemOffset  = {A{1'b0}};
        MemDataIn  = {W{1'b0}};
        case (r_state)
            ACCESS: begin
                MemAddress = r_addr;
                MemOffset  = r_offset;
                if (op_is_store(r_op)) begin
                    MemWriteEn = 1'b1;
                    MemDataIn  = r_data;
                end else begin
                    MemWriteEn = 1'b0;
                    MemDataIn  = {W{1'b0}};
                end
            end
            COPY_RD: begin
                MemAddress = r_addr + r_idx;
            end
            COPY_WR: begin
                MemAddress = r_dst + r_idx;
                MemWriteEn = 1'b1;
                MemDataIn  = r_buf;
            end
            default: begin
                MemWriteEn = 1'b0;
            end
        endcase
    end

    // Request capture, copy index/buffer and the registered response.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_op        <= OP_LOAD;
            r_addr      <= {A{1'b0}};
            r_offset    <= {A{1'b0}};
            r_dst       <= {A{1'b0}};
            r_len       <= {A{1'b0}};
            r_data      <= {W{1'b0}};
            r_idx       <= {A{1'b0}};
            r_buf       <= {W{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {W{1'b0}};
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_req_op;
                        r_addr   <= ReqAddr;
                        r_offset <= ReqOffset;
                        r_dst    <= ReqDst;
                        r_len    <= ReqLen;
                        r_data   <= ReqData;
                        r_idx    <= {A{1'b0}};
                        if ((w_req_op == OP_COPY) && (ReqLen == {A{1'b0}})) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= {W{1'b0}};
                        end
                    end
                end
                ACCESS: begin
                    r_rsp_valid <= 1'b1;
                    if (op_is_store(r_op)) begin
                        r_rsp_data <= r_data;
                    end else begin
                        r_rsp_data <= MemDataOut;
                    end
                end
                COPY_RD: begin
                    r_buf <= MemDataOut;
                end
                COPY_WR: begin
                    r_idx <= w_idx_next;
                    if (w_last) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= W'(r_len);
                    end
                end
                default: begin
                    r_idx <= {A{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_master.sv
// Scoreboard bench for dmem_master with a 256-byte combinational-read memory.
module tb_dmem_master;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ReqValid = 1'b0;
    logic       ReqReady;
    logic [1:0] ReqOp = 2'b00;
    logic [7:0] ReqAddr = 8'h00, ReqOffset = 8'h00, ReqDst = 8'h00, ReqLen = 8'h00, ReqData = 8'h00;
    logic       RspValid;
    logic [7:0] RspData;
    logic       Busy, MemWriteEn;
    logic [7:0] MemAddress, MemOffset, MemDataIn, MemDataOut;

    dmem_master dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqOffset(ReqOffset), .ReqDst(ReqDst),
        .ReqLen(ReqLen), .ReqData(ReqData), .RspValid(RspValid), .RspData(RspData),
        .Busy(Busy), .MemWriteEn(MemWriteEn), .MemAddress(MemAddress),
        .MemOffset(MemOffset), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
    );

    always #5 Clk = ~Clk;

    // Memory model: combinational read of address+offset, write on rising edge.
    logic [7:0] mem [0:255] = '{default: 8'h00};
    logic [7:0] rd_idx;
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;
    int         wr_count = 0;
    assign rd_idx     = MemAddress + MemOffset;
    assign MemDataOut = mem[rd_idx];

    always @(posedge Clk) begin
        if (MemWriteEn) begin
            mem[rd_idx] <= MemDataIn;
            wr_count    <= wr_count + 1;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] data; int cyc; } exp_t;
    exp_t exp_q[$];
    int checks = 0, passes = 0, rsp_seen = 0, n_exp = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge Clk) begin
        if (!Reset && RspValid) begin
            exp_t e;
            rsp_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", {24'd0, RspData}, {24'd0, e.data});
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge Clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] off,
                        input logic [7:0] dst, input logic [7:0] len, input logic [7:0] data,
                        input logic [7:0] exp_d, input int lat, input bit exp_rsp, output int acc);
        int n = 0;
        @(negedge Clk);
        ReqOp = op; ReqAddr = addr; ReqOffset = off; ReqDst = dst; ReqLen = len; ReqData = data;
        ReqValid = 1'b1;
        while (!ReqReady && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!ReqReady) begin
            chk("accept_timeout", 32'd0, 32'd1);
            ReqValid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc;
            if (exp_rsp) begin
                exp_q.push_back('{data: exp_d, cyc: cyc + lat});
                n_exp++;
            end
            @(posedge Clk);
            #1 ReqValid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || Busy) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
        @(negedge Clk);
    endtask

    initial begin
        int acc, acc2, wc;
        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_ready", {31'd0, ReqReady}, 32'd0);
        chk("rst_outs", {Busy, MemWriteEn, RspValid, RspData, MemAddress, MemOffset, MemDataIn}, 32'd0);
        Reset = 1'b0;
        #1 chk("ready_after_rst", {31'd0, ReqReady}, 32'd1);

        // Store then load
        send(2'b01, 8'h10, 8'h03, 8'h00, 8'h00, 8'hA5, 8'hA5, 2, 1'b1, acc);
        drain();
        chk("store_mem", {24'd0, mem[8'h13]}, 32'hA5);
        send(2'b00, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00, 8'hA5, 2, 1'b1, acc);
        drain();

        // Load with address wrap
        preload(8'h01, 8'h3C);
        send(2'b00, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h3C, 2, 1'b1, acc);
        drain();

        // Four-byte copy
        preload(8'h20, 8'h11); preload(8'h21, 8'h22); preload(8'h22, 8'h33); preload(8'h23, 8'h44);
        send(2'b10, 8'h20, 8'h00, 8'h80, 8'h04, 8'h00, 8'h04, 9, 1'b1, acc);
        drain();
        chk("copy_mem", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}, 32'h11223344);

        // Reserved opcode behaves as a load
        send(2'b11, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h22, 2, 1'b1, acc);
        drain();

        // Overlapping forward copy replicates the first byte
        preload(8'h40, 8'h7E);
        send(2'b10, 8'h40, 8'h00, 8'h41, 8'h03, 8'h00, 8'h03, 7, 1'b1, acc);
        drain();
        chk("overlap_mem", {8'h00, mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h007E7E7E);

        // Zero-length copy: response after one cycle, no write
        wc = wr_count;
        send(2'b10, 8'h20, 8'h00, 8'h90, 8'h00, 8'h00, 8'h00, 1, 1'b1, acc);
        drain();
        chk("zero_copy_writes", wr_count, wc);

        // Reset during the third COPY_WR of a four-byte copy
        send(2'b10, 8'h20, 8'h00, 8'hA0, 8'h04, 8'h00, 8'h00, 0, 1'b0, acc);
        while (cyc != acc + 6 && cyc < acc + 20) @(negedge Clk);
        chk("third_wr_active", {31'd0, MemWriteEn}, 32'd1);
        Reset = 1'b1;
        #1 chk("rst_we_drop", {30'd0, MemWriteEn, Busy}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1 chk("rst_ready_back", {31'd0, ReqReady}, 32'd1);
        chk("rst_copy_mem", {mem[8'hA0], mem[8'hA1], mem[8'hA2], mem[8'hA3]}, 32'h11220000);
        repeat (4) @(negedge Clk);

        // Store held during a copy waits for ReqReady
        send(2'b10, 8'h20, 8'h00, 8'hC0, 8'h02, 8'h00, 8'h02, 5, 1'b1, acc);
        send(2'b01, 8'h30, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A, 2, 1'b1, acc2);
        chk("store_wait", acc2 - acc, 32'd5);
        drain();
        repeat (3) @(negedge Clk);
        chk("busy_mem", {16'd0, mem[8'hC0], mem[8'hC1]}, 32'h1122);
        chk("store_mem2", {24'd0, mem[8'h30]}, 32'h5A);

        chk("rsp_count", rsp_seen, n_exp);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
